// File: rtl/conv1d_pkg.sv
// Shared constants and configuration type for the conv1d requantize/pack stage.
// Q31 fixed-point constants are sized for the full 64-bit product.
package conv1d_pkg;

  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;
  localparam int PACK   = 4;
  localparam int IDX_W  = $clog2(PACK);
  localparam int CNT_W  = IDX_W + 1;
  localparam int PROD_W = 2 * ACC_W;
  localparam int SHF_W  = 5;

  localparam logic signed [PROD_W-1:0] Q31_NUDGE_POS  = 64'sh0000_0000_4000_0000;
  localparam logic signed [PROD_W-1:0] Q31_NUDGE_NEG  = 64'shFFFF_FFFF_C000_0001;
  // Added before an arithmetic shift so negative quotients truncate toward zero.
  localparam logic signed [PROD_W-1:0] Q31_TRUNC_BIAS = 64'sh0000_0000_7FFF_FFFF;

  localparam logic signed [ACC_W-1:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [ACC_W-1:0] INT32_MAX = 32'sh7FFF_FFFF;

  typedef struct packed {
    logic signed [ACC_W-1:0] mult;
    logic        [SHF_W-1:0] shift;
    logic signed [ACC_W-1:0] offset;
    logic signed [OUT_W-1:0] act_min;
    logic signed [OUT_W-1:0] act_max;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    mult:    32'sh4000_0000,
    shift:   5'd0,
    offset:  32'sh0000_0000,
    act_min: 8'sh80,
    act_max: 8'sh7F
  };

endpackage

// File: rtl/conv1d_requant_core.sv
// Three-stage int8 requantization pipeline: Q31 multiply, SRDHM, rounding shift
// with offset and clamp. Valid and last ride alongside; everything holds when en_i=0.
module conv1d_requant_core
  import conv1d_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    vld_i,
  input  logic                    last_i,
  input  logic signed [ACC_W-1:0] data_i,
  input  cfg_t                    cfg_i,
  output logic                    vld_o,
  output logic                    last_o,
  output logic        [OUT_W-1:0] data_o,
  output logic                    busy_o
);

  function automatic logic signed [PROD_W-1:0] mul_full(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [PROD_W-1:0] ae;
    logic [PROD_W-1:0] be;
    ae = {{ACC_W{a[ACC_W-1]}}, a};
    be = {{ACC_W{b[ACC_W-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic signed [ACC_W-1:0] srdhm(
    input logic signed [PROD_W-1:0] p,
    input logic                     sat
  );
    logic signed [PROD_W-1:0] sum;
    logic signed [PROD_W-1:0] quo;
    sum = p + ((p >= 0) ? Q31_NUDGE_POS : Q31_NUDGE_NEG);
    if (sum < 0) quo = (sum + Q31_TRUNC_BIAS) >>> 31;
    else         quo = sum >>> 31;
    return sat ? INT32_MAX : quo[ACC_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] requant(
    input logic signed [ACC_W-1:0] x,
    input cfg_t                    c
  );
    logic        [ACC_W-1:0] mask;
    logic        [ACC_W-1:0] rem;
    logic        [ACC_W-1:0] thr;
    logic signed [ACC_W-1:0] y;
    logic signed [ACC_W:0]   z;
    logic signed [ACC_W:0]   lo;
    logic signed [ACC_W:0]   hi;
    mask = (32'd1 << c.shift) - 32'd1;
    rem  = x & mask;
    thr  = (mask >> 1) + {31'd0, x[ACC_W-1]};
    y    = (x >>> c.shift) + ((rem > thr) ? 32'sd1 : 32'sd0);
    // One extra bit so a large zero-point cannot wrap before the clamp.
    z    = {y[ACC_W-1], y} + {c.offset[ACC_W-1], c.offset};
    lo   = {{(ACC_W+1-OUT_W){c.act_min[OUT_W-1]}}, c.act_min};
    hi   = {{(ACC_W+1-OUT_W){c.act_max[OUT_W-1]}}, c.act_max};
    if (z < lo)      z = lo;
    else if (z > hi) z = hi;
    return z[OUT_W-1:0];
  endfunction

  logic                     vld_p1, vld_p2, vld_p3;
  logic                     last_p1, last_p2, last_p3;
  logic                     sat_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]  x_p2;
  logic        [OUT_W-1:0]  q_p3;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (en_i) begin
      vld_p1 <= vld_i;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      // Stage 1: full-width product
      prod_p1 <= mul_full(data_i, cfg_i.mult);
      sat_p1  <= (data_i == INT32_MIN) && (cfg_i.mult == INT32_MIN);
      last_p1 <= last_i;
      // Stage 2: saturating rounding doubling high multiply
      x_p2    <= srdhm(prod_p1, sat_p1);
      last_p2 <= last_p1;
      // Stage 3: rounding divide, zero-point, activation clamp
      q_p3    <= requant(x_p2, cfg_i);
      last_p3 <= last_p2;
    end
  end

  assign vld_o  = vld_p3;
  assign last_o = last_p3;
  assign data_o = q_p3;
  assign busy_o = vld_p1 | vld_p2 | vld_p3;

endmodule

// File: rtl/conv1d_requant_pack.sv
// Requantizes the conv1d accumulator stream to int8 and packs four results per
// word, element 0 in the top byte, matching the CFU input buffer byte order.
module conv1d_requant_pack #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int PACK  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  input  logic [ACC_W-1:0]      cfg_multiplier,
  input  logic [4:0]            cfg_shift,
  input  logic [ACC_W-1:0]      cfg_offset,
  input  logic [OUT_W-1:0]      cfg_act_min,
  input  logic [OUT_W-1:0]      cfg_act_max,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_W-1:0]      in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACK*OUT_W-1:0] out_data,
  output logic [2:0]            out_count,
  output logic                  busy
);

  import conv1d_pkg::IDX_W;
  import conv1d_pkg::CNT_W;
  import conv1d_pkg::cfg_t;
  import conv1d_pkg::CFG_DEFAULT;

  localparam int WORD_W = PACK * OUT_W;

  function automatic logic [WORD_W-1:0] put_byte(
    input logic [WORD_W-1:0] w,
    input logic [IDX_W-1:0]  k,
    input logic [OUT_W-1:0]  b
  );
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < PACK; i++) begin
      if (k == IDX_W'(i)) r[WORD_W-1-OUT_W*i -: OUT_W] = b;
    end
    return r;
  endfunction

  // Zero every byte after position k so a short flush never leaks stale bytes.
  function automatic logic [WORD_W-1:0] keep_upto(
    input logic [WORD_W-1:0] w,
    input logic [IDX_W-1:0]  k
  );
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < PACK; i++) begin
      if (IDX_W'(i) > k) r[WORD_W-1-OUT_W*i -: OUT_W] = '0;
    end
    return r;
  endfunction

  cfg_t              cfg_q;
  logic              stall;
  logic              adv;
  logic              core_vld;
  logic              core_last;
  logic              core_busy;
  logic [OUT_W-1:0]  core_byte;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovld_q, ovld_d;

  assign stall    = ovld_q && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;
  assign busy     = core_busy || (idx_q != '0) || ovld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q <= CFG_DEFAULT;
    end else if (cfg_valid && !busy) begin
      cfg_q <= '{
        mult:    cfg_multiplier,
        shift:   cfg_shift,
        offset:  cfg_offset,
        act_min: cfg_act_min,
        act_max: cfg_act_max
      };
    end
  end

  conv1d_requant_core u_core (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (adv),
    .vld_i  (in_valid),
    .last_i (in_last),
    .data_i (in_data),
    .cfg_i  (cfg_q),
    .vld_o  (core_vld),
    .last_o (core_last),
    .data_o (core_byte),
    .busy_o (core_busy)
  );

  always_comb begin
    idx_d  = idx_q;
    acc_d  = acc_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    ovld_d = ovld_q;
    if (adv) begin
      if (ovld_q && out_ready) ovld_d = 1'b0;
      if (core_vld) begin
        acc_d = put_byte(acc_q, idx_q, core_byte);
        if (idx_q == IDX_W'(PACK-1) || core_last) begin
          // A completed word may replace one being handed off this same cycle.
          word_d = keep_upto(acc_d, idx_q);
          cnt_d  = {1'b0, idx_q} + CNT_W'(1);
          ovld_d = 1'b1;
          idx_d  = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
      cnt_q  <= '0;
      ovld_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      ovld_q <= ovld_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign out_valid = ovld_q;
  assign out_data  = word_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_conv1d_requant_pack.sv
// Directed bench for conv1d_requant_pack: single-element vector table plus
// hand-written multi-cycle sequences (packing, backpressure, reset, config).
module tb_conv1d_requant_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [31:0] cfg_multiplier;
  logic [4:0]  cfg_shift;
  logic [31:0] cfg_offset;
  logic [7:0]  cfg_act_min;
  logic [7:0]  cfg_act_max;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_data[$];
  logic [2:0]  q_cnt[$];

  conv1d_requant_pack dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_multiplier (cfg_multiplier),
    .cfg_shift      (cfg_shift),
    .cfg_offset     (cfg_offset),
    .cfg_act_min    (cfg_act_min),
    .cfg_act_max    (cfg_act_max),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_count      (out_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_cnt.push_back(out_count);
    end
  end

  typedef struct {
    logic [31:0] mult;
    logic [4:0]  shift;
    logic [31:0] off;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [31:0] acc;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic do_cfg(input logic [31:0] m, input logic [4:0] s, input logic [31:0] o,
                        input logic [7:0] mn, input logic [7:0] mx);
    cfg_multiplier = m;
    cfg_shift      = s;
    cfg_offset     = o;
    cfg_act_min    = mn;
    cfg_act_max    = mx;
    cfg_valid      = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("send_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) fail_now(nm);
  endtask

  task automatic expect_word(input string nm, input logic [31:0] d, input logic [2:0] c);
    int n;
    logic [31:0] gd;
    logic [2:0]  gc;
    n = 0;
    while (q_data.size() == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q_data.size() == 0) begin
      fail_now(nm);
    end else begin
      gd = q_data.pop_front();
      gc = q_cnt.pop_front();
      check({nm, "_data"}, gd, d);
      check({nm, "_count"}, 32'(gc), 32'(c));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic [31:0] held;

    vecs[0]  = '{32'h4000_0000, 5'd0,  32'h0000_0000, 8'h80, 8'h7F, 32'd50,        8'h19};
    vecs[1]  = '{32'h4000_0000, 5'd0,  32'h0000_0000, 8'h80, 8'h7F, 32'hFFFF_FFCD, 8'hE7};
    vecs[2]  = '{32'h4000_0000, 5'd2,  32'h0000_0000, 8'h80, 8'h7F, 32'd10,        8'h01};
    vecs[3]  = '{32'h4000_0000, 5'd2,  32'h0000_0000, 8'h80, 8'h7F, 32'd14,        8'h02};
    vecs[4]  = '{32'h4000_0000, 5'd2,  32'h0000_0000, 8'h80, 8'h7F, 32'hFFFF_FFF2, 8'hFE};
    vecs[5]  = '{32'h4000_0000, 5'd2,  32'h0000_0000, 8'h80, 8'h7F, 32'hFFFF_FFF6, 8'hFF};
    vecs[6]  = '{32'h4000_0000, 5'd1,  32'h0000_0000, 8'h80, 8'h7F, 32'hFFFF_FFFA, 8'hFE};
    vecs[7]  = '{32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 8'h80, 8'h7F, 32'h7FFF_FFFF, 8'h01};
    vecs[8]  = '{32'h4000_0000, 5'd0,  32'd100,       8'h80, 8'h7F, 32'd40,        8'h78};
    vecs[9]  = '{32'h4000_0000, 5'd0,  32'd100,       8'h80, 8'h7F, 32'd100,       8'h7F};
    vecs[10] = '{32'h4000_0000, 5'd0,  32'h0000_0000, 8'hF6, 8'h14, 32'd100,       8'h14};
    vecs[11] = '{32'h4000_0000, 5'd0,  32'h0000_0000, 8'hF6, 8'h14, 32'hFFFF_FF9C, 8'hF6};
    vecs[12] = '{32'h4000_0000, 5'd0,  32'h7FFF_FFFF, 8'h80, 8'h7F, 32'd2,         8'h7F};
    vecs[13] = '{32'h0000_0000, 5'd0,  32'hFFFF_FFFB, 8'h80, 8'h7F, 32'd12345,     8'hFB};

    reset = 1'b1;
    cfg_valid = 1'b0;
    cfg_multiplier = '0;
    cfg_shift = '0;
    cfg_offset = '0;
    cfg_act_min = '0;
    cfg_act_max = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      do_cfg(vecs[i].mult, vecs[i].shift, vecs[i].off, vecs[i].mn, vecs[i].mx);
      send(vecs[i].acc, 1'b1);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      expect_word($sformatf("vec%0d", i), {vecs[i].exp_b, 24'h0}, 3'd1);
      wait_idle("vec_idle");
    end

    do_cfg(32'h4000_0000, 5'd0, 32'h0, 8'h80, 8'h7F);
    send(32'd50, 1'b0);
    send(32'd60, 1'b0);
    send(32'd69, 1'b0);
    send(32'd77, 1'b1);
    expect_word("full_word", 32'h191E_2327, 3'd4);
    wait_idle("full_idle");

    do_cfg(32'h4000_0000, 5'd1, 32'hFFFF_FF80, 8'h80, 8'h7F);
    send(32'd100, 1'b0);
    send(32'd7, 1'b1);
    expect_word("round_word", 32'h9982_0000, 3'd2);
    wait_idle("round_idle");

    do_cfg(32'h8000_0000, 5'd0, 32'h0, 8'h80, 8'h7F);
    send(32'hFFFF_FC18, 1'b0);
    send(32'd1000, 1'b0);
    send(32'h8000_0000, 1'b1);
    expect_word("clamp_word", 32'h7F80_7F00, 3'd3);
    wait_idle("clamp_idle");

    do_cfg(32'h4000_0000, 5'd0, 32'h0, 8'h80, 8'h7F);
    send(32'd10, 1'b1);
    send(32'd12, 1'b1);
    send(32'd14, 1'b1);
    expect_word("b2b_w0", 32'h0500_0000, 3'd1);
    expect_word("b2b_w1", 32'h0600_0000, 3'd1);
    expect_word("b2b_w2", 32'h0700_0000, 3'd1);
    wait_idle("b2b_idle");

    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(32'(2 * i + 10), i == 11);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 60) begin
          @(negedge clk);
          n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        held = out_data;
        check("bp_first_word", held, 32'h0506_0708);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check($sformatf("bp_stable%0d", k), out_data, held);
          check($sformatf("bp_stall_ready%0d", k), 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    expect_word("bp_w0", 32'h0506_0708, 3'd4);
    expect_word("bp_w1", 32'h090A_0B0C, 3'd4);
    expect_word("bp_w2", 32'h0D0E_0F10, 3'd4);
    wait_idle("bp_idle");
    check("bp_no_extra", 32'(q_data.size()), 32'd0);

    do_cfg(32'h4000_0000, 5'd0, 32'h0, 8'h80, 8'h7F);
    send(32'd50, 1'b0);
    send(32'd60, 1'b0);
    do_cfg(32'h4000_0000, 5'd5, 32'h0, 8'h80, 8'h7F);
    send(32'd69, 1'b0);
    send(32'd77, 1'b1);
    expect_word("cfg_busy_word", 32'h191E_2327, 3'd4);
    wait_idle("cfg_busy_idle");
    do_cfg(32'h4000_0000, 5'd5, 32'h0, 8'h80, 8'h7F);
    send(32'd1600, 1'b1);
    expect_word("cfg_idle_word", 32'h1900_0000, 3'd1);
    wait_idle("cfg_idle_idle");

    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    @(posedge clk);
    #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_out_data",  out_data,       32'd0);
    check("mid_out_count", 32'(out_count), 32'd0);
    check("mid_busy",      32'(busy),      32'd0);
    check("mid_in_ready",  32'(in_ready),  32'd1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(32'd20, 1'b0);
    send(32'd22, 1'b0);
    send(32'd24, 1'b0);
    send(32'd26, 1'b1);
    expect_word("post_rst_word", 32'h0A0B_0C0D, 3'd4);
    wait_idle("post_rst_idle");
    check("post_rst_no_stray", 32'(q_data.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
